// File: rtl/alu_sequencer.sv
// Front-end sequencer for the 8-bit ALU: queues operations in a FIFO, issues one
// at a time, waits a fixed datapath latency and returns the result on valid/ready.
module alu_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_result,
  output logic [3:0]  out_opcode,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [3:0] OPC_NOP = 4'b0111;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  op_t              mem [DEPTH];
  op_t              head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             push, pop;

  // Full/empty come from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready = (count != (PTR_W + 1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign busy     = (state != IDLE) || (count != '0);
  assign head     = mem[rd_ptr];

  // NOTE: payload storage has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_opcode, in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_opcode <= OPC_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opcode <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_opcode <= head.opcode;
            alu_a      <= head.a;
            alu_b      <= head.b;
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            out_result <= alu_result;
            out_opcode <= alu_opcode;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Holding here is what stalls issue under back-pressure.
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a combinational datapath stub
// (0010 add, 0011 subtract, anything else xor).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [7:0]  in_a, in_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic [7:0]  alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_result;
  logic [3:0]  out_opcode;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.DEPTH(4), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode)
      4'h2:    alu_result = alu_a + alu_b;
      4'h3:    alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one op at a negedge and hold it until an edge accepts it.
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic acc;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (out_valid) return;
      @(negedge clk);
    end
    check("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  logic [11:0] exp_res [6];
  int          got;
  logic        pushed_prev;
  int          seen_valid;

  initial begin
    exp_res = '{12'h21E, 12'h340, 12'h5FF, 12'h200, 12'h3FF, 12'h9AA};
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset for two edges, then idle state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 32'h7);
    check("rst_op_count",   {16'd0, op_count},   32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_out_result", {24'd0, out_result}, 32'd0);

    // Single op: 0010 5+3.
    push(4'h2, 8'h05, 8'h03);
    check("single_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_alu_opcode", {28'd0, alu_opcode}, 32'h2);
    check("single_alu_a",      {24'd0, alu_a},      32'h05);
    check("single_alu_b",      {24'd0, alu_b},      32'h03);
    check("single_valid_e1",   {31'd0, out_valid},  32'd0);
    @(negedge clk);
    check("single_valid_e2",   {31'd0, out_valid},  32'd0);
    @(negedge clk);
    check("single_valid_e3",   {31'd0, out_valid},  32'd1);
    check("single_result",     {24'd0, out_result}, 32'h08);
    check("single_out_opcode", {28'd0, out_opcode}, 32'h2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_op_count",  {16'd0, op_count},  32'd1);
    check("single_valid_clr", {31'd0, out_valid}, 32'd0);
    check("single_idle_busy", {31'd0, busy},      32'd0);

    // Fill: five ops back-to-back with out_ready low -> 1 issued, 4 queued.
    push(4'h2, 8'd10,  8'd20);
    push(4'h3, 8'h50,  8'h10);
    push(4'h5, 8'hF0,  8'h0F);
    push(4'h2, 8'hFF,  8'h01);
    push(4'h3, 8'h00,  8'h01);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);

    // Sixth op offered while full; back-pressure held for 10 cycles.
    in_valid = 1'b1; in_opcode = 4'h9; in_a = 8'hA5; in_b = 8'h0F;
    repeat (10) @(negedge clk);
    check("bp_in_ready",   {31'd0, in_ready},   32'd0);
    check("bp_out_valid",  {31'd0, out_valid},  32'd1);
    check("bp_out_result", {24'd0, out_result}, 32'h1E);
    check("bp_out_opcode", {28'd0, out_opcode}, 32'h2);
    check("bp_alu_opcode", {28'd0, alu_opcode}, 32'h2);
    check("bp_alu_a",      {24'd0, alu_a},      32'd10);
    check("bp_alu_b",      {24'd0, alu_b},      32'd20);

    // Drain: all six results in push order.
    out_ready   = 1'b1;
    got         = 0;
    pushed_prev = 1'b0;
    for (int i = 0; i < 100 && got < 6; i++) begin
      if (out_valid) begin
        check($sformatf("order_%0d", got), {20'd0, out_opcode, out_result}, {20'd0, exp_res[got]});
        got++;
      end
      if (pushed_prev) in_valid = 1'b0;
      pushed_prev = in_valid && in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("drain_count",    got,                 32'd6);
    check("drain_op_count", {16'd0, op_count},   32'd7);
    check("drain_busy",     {31'd0, busy},       32'd0);

    // Reset in WAIT with two ops queued.
    out_ready = 1'b0;
    push(4'h2, 8'h11, 8'h22);
    push(4'h2, 8'h33, 8'h44);
    push(4'h2, 8'h55, 8'h66);
    check("mid_busy",      {31'd0, busy},      32'd1);
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("mid_rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("mid_rst_busy",       {31'd0, busy},       32'd0);
    check("mid_rst_alu_opcode", {28'd0, alu_opcode}, 32'h7);
    check("mid_rst_op_count",   {16'd0, op_count},   32'd0);
    out_ready  = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen_valid++;
      @(negedge clk);
    end
    check("mid_no_emit", seen_valid, 32'd0);

    // Counter wrap from FFFF.
    out_ready = 1'b0;
    push(4'h2, 8'h01, 8'h01);
    wait_valid();
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    check("wrap_preload", {16'd0, op_count},   32'hFFFF);
    check("wrap_result",  {24'd0, out_result}, 32'h02);
    out_ready = 1'b1;
    @(negedge clk);
    check("wrap_op_count", {16'd0, op_count},  32'h0000);
    check("wrap_valid",    {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
